// File: rtl/seq_normalizer_if.sv
// Handshake/result bundle for seq_normalizer: request side driven by the master,
// status and normalized result driven by the slave (the normalizer).
interface seq_normalizer_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    shift_amt;
  logic             zero;

  modport master (
    output start, mode, data_in,
    input  busy, done, data_out, shift_amt, zero
  );

  modport slave (
    input  start, mode, data_in,
    output busy, done, data_out, shift_amt, zero
  );
endinterface

// File: rtl/seq_normalizer.sv
// Sequential normalizer: shifts an operand one bit per clock until the target end
// bit is 1, reporting the normalized word and the number of positions shifted.
module seq_normalizer #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  seq_normalizer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    count;
  logic             mode_q;
  logic             target;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] data_out_q;
  logic [CW-1:0]    shift_amt_q;
  logic             zero_q;

  // mode 0 hunts for a 1 in the MSB, mode 1 in the LSB
  always_comb begin
    target = mode_q ? work[0] : work[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      work        <= '0;
      count       <= '0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      data_out_q  <= '0;
      shift_amt_q <= '0;
      zero_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            work   <= bus.data_in;
            mode_q <= bus.mode;
            count  <= '0;
            if (bus.data_in == '0) begin
              // nothing to normalize: report immediately without going busy
              data_out_q  <= '0;
              shift_amt_q <= '0;
              zero_q      <= 1'b1;
              done_q      <= 1'b1;
            end else begin
              busy_q <= 1'b1;
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (target) begin
            data_out_q  <= work;
            shift_amt_q <= count;
            zero_q      <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end else begin
            work  <= mode_q ? (work >> 1) : (work << 1);
            count <= count + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.data_out  = data_out_q;
  assign bus.shift_amt = shift_amt_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_seq_normalizer.sv
// Scoreboard bench for seq_normalizer (WIDTH=8): expected results queued at start,
// checked with completion cycle when done pulses.
module tb_seq_normalizer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_normalizer_if #(.WIDTH(8)) bus ();

  seq_normalizer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [2:0]  amt;
    logic        zero;
    int unsigned edge_no;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned done_seen = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic exp_t model(input logic m, input logic [7:0] d);
    exp_t        e;
    logic [7:0]  w;
    int unsigned n;
    w = d;
    n = 0;
    if (d == 8'h00) begin
      e.data = 8'h00; e.amt = 3'd0; e.zero = 1'b1; e.edge_no = 0;
      return e;
    end
    while (!(m ? w[0] : w[7])) begin
      w = m ? (w >> 1) : (w << 1);
      n++;
    end
    e.data = w; e.amt = 3'(n); e.zero = 1'b0; e.edge_no = n + 1;
    return e;
  endfunction

  // Completion monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_seen++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (bus.data_out !== mon_e.data) begin
          bad++;
          $display("FAIL data_out: got %b required %b", bus.data_out, mon_e.data);
        end
        total++;
        if (bus.shift_amt !== mon_e.amt) begin
          bad++;
          $display("FAIL shift_amt: got %0d required %0d", bus.shift_amt, mon_e.amt);
        end
        total++;
        if (bus.zero !== mon_e.zero) begin
          bad++;
          $display("FAIL zero: got %b required %b", bus.zero, mon_e.zero);
        end
        total++;
        if (cyc !== mon_e.edge_no) begin
          bad++;
          $display("FAIL latency: done after edge %0d required edge %0d", cyc, mon_e.edge_no);
        end
        total++;
        if (bus.busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_at_done: got %b required 0", bus.busy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic m, input logic [7:0] d);
    exp_t e;
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.data_in = d;
    e = model(m, d);
    e.edge_no = e.edge_no + cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d results outstanding after %0d cycles, required 0", sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.mode = 1'b0; bus.data_in = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.data_out, bus.shift_amt, bus.zero} !== 13'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b data_out=%b shift_amt=%0d zero=%b, required all 0",
               bus.busy, bus.done, bus.data_out, bus.shift_amt, bus.zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_left;
    issue(1'b0, 8'b00011101);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_rise: got %b required 1", bus.busy);
    end
    wait_idle(20);
    total++;
    if (bus.data_out !== 8'b11101000 || bus.shift_amt !== 3'd3 || bus.zero !== 1'b0) begin
      bad++;
      $display("FAIL left_norm: got %b/%0d/%b required 11101000/3/0", bus.data_out, bus.shift_amt, bus.zero);
    end
  endtask

  task automatic test_right;
    issue(1'b1, 8'b10011100);
    wait_idle(20);
    total++;
    if (bus.data_out !== 8'b00100111 || bus.shift_amt !== 3'd2) begin
      bad++;
      $display("FAIL right_norm: got %b/%0d required 00100111/2", bus.data_out, bus.shift_amt);
    end
  endtask

  task automatic test_boundaries;
    issue(1'b0, 8'b10011101);
    wait_idle(20);
    total++;
    if (bus.data_out !== 8'b10011101 || bus.shift_amt !== 3'd0) begin
      bad++;
      $display("FAIL already_norm: got %b/%0d required 10011101/0", bus.data_out, bus.shift_amt);
    end
    issue(1'b0, 8'b00000001);
    wait_idle(20);
    total++;
    if (bus.data_out !== 8'b10000000 || bus.shift_amt !== 3'd7) begin
      bad++;
      $display("FAIL worst_case: got %b/%0d required 10000000/7", bus.data_out, bus.shift_amt);
    end
  endtask

  task automatic test_zero;
    int unsigned busy_hits = 0;
    for (int unsigned m = 0; m < 2; m++) begin
      issue(m[0], 8'h00);
      for (int unsigned k = 0; k < 3; k++) begin
        @(negedge clk);
        if (bus.busy) busy_hits++;
      end
      wait_idle(5);
      total++;
      if (bus.zero !== 1'b1 || bus.data_out !== 8'h00 || bus.shift_amt !== 3'd0) begin
        bad++;
        $display("FAIL zero_op: got zero=%b data_out=%b shift_amt=%0d required 1/0/0",
                 bus.zero, bus.data_out, bus.shift_amt);
      end
    end
    total++;
    if (busy_hits !== 0) begin
      bad++;
      $display("FAIL zero_busy: busy high %0d cycles, required 0", busy_hits);
    end
    issue(1'b1, 8'b01000000);
    wait_idle(20);
    total++;
    if (bus.zero !== 1'b0 || bus.data_out !== 8'b00000001 || bus.shift_amt !== 3'd6) begin
      bad++;
      $display("FAIL zero_clear: got %b/%b/%0d required 0/00000001/6", bus.zero, bus.data_out, bus.shift_amt);
    end
  endtask

  task automatic test_ignored_start;
    int unsigned d0;
    d0 = done_seen;
    issue(1'b0, 8'b00000100);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = 1'b1; bus.data_in = 8'hFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle(20);
    repeat (10) @(negedge clk);
    total++;
    if (done_seen - d0 !== 1) begin
      bad++;
      $display("FAIL ignored_start_dones: got %0d done pulses required 1", done_seen - d0);
    end
    total++;
    if (bus.data_out !== 8'b10000000 || bus.shift_amt !== 3'd5) begin
      bad++;
      $display("FAIL ignored_start_result: got %b/%0d required 10000000/5", bus.data_out, bus.shift_amt);
    end
  endtask

  task automatic test_reset_mid;
    int unsigned d0;
    issue(1'b0, 8'b00000001);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.data_out, bus.shift_amt, bus.zero} !== 13'd0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b data_out=%b shift_amt=%0d zero=%b, required all 0",
               bus.busy, bus.done, bus.data_out, bus.shift_amt, bus.zero);
    end
    sb.delete();
    d0 = done_seen;
    #20;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if (done_seen !== d0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_abandon: %0d dones busy=%b after release, required 0 dones busy=0",
               done_seen - d0, bus.busy);
    end
    issue(1'b1, 8'b10100000);
    wait_idle(20);
    total++;
    if (bus.data_out !== 8'b00000101 || bus.shift_amt !== 3'd5) begin
      bad++;
      $display("FAIL after_reset: got %b/%0d required 00000101/5", bus.data_out, bus.shift_amt);
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0]  ops [4];
    exp_t        e;
    int unsigned k;
    ops[0] = {1'b0, 8'b00100000};
    ops[1] = {1'b1, 8'b00000110};
    ops[2] = {1'b0, 8'b10000000};
    ops[3] = {1'b1, 8'b00000000};
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = ops[0][8]; bus.data_in = ops[0][7:0];
    e = model(ops[0][8], ops[0][7:0]);
    e.edge_no = e.edge_no + cyc + 1;
    sb.push_back(e);
    for (int unsigned i = 1; i < 4; i++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!bus.done && k < 20);
      if (!bus.done) begin
        total++;
        bad++;
        $display("FAIL b2b_wait: no done for op %0d within 20 cycles, required done", i - 1);
        break;
      end
      // accept the next request in the same cycle done is high
      bus.mode = ops[i][8]; bus.data_in = ops[i][7:0];
      e = model(ops[i][8], ops[i][7:0]);
      e.edge_no = e.edge_no + cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle(20);
  endtask

  task automatic test_random;
    for (int unsigned i = 0; i < 12; i++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      wait_idle(20);
    end
  endtask

  initial begin
    test_reset();
    test_left();
    test_right();
    test_boundaries();
    test_zero();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
